ped_crossing_ctrl: RTL and testbench

Parametrised, request-driven successor to the fixed-cycle pedestrian light controller. Road green is held until a debounced pedestrian push-button request arrives and a minimum green time has elapsed. It then sequences yellow, all-red, pedestrian green, flashing pedestrian clearance and all-red back to road green. It sits directly between the board clock/button pins and the five lamp outputs; all outputs are registered.

---
 rtl/ped_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/ped_crossing_ctrl.sv | 129 ++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing controller:
// phase encoding, lamp patterns and seconds-counter width.
package ped_pkg;

   localparam int unsigned SEC_W = 8;

   typedef enum logic [2:0] {
      ALLRED0    = 3'd0,
      ROADGREEN  = 3'd1,
      ROADYELLOW = 3'd2,
      ALLRED1    = 3'd3,
      PEDGREEN   = 3'd4,
      PEDCLEAR   = 3'd5,
      ALLRED2    = 3'd6
   } state_t;

   // Lamp vector order: {ped_red, ped_green, red, yellow, green}
   typedef logic [4:0] lamps_t;

   localparam lamps_t LAMPS_ALLRED     = 5'b10100;
   localparam lamps_t LAMPS_ROADGREEN  = 5'b10001;
   localparam lamps_t LAMPS_ROADYELLOW = 5'b10010;
   localparam lamps_t LAMPS_PEDGREEN   = 5'b01100;

   function automatic logic [SEC_W-1:0] last_sec(input int unsigned dur);
      return SEC_W'(dur - 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw
// button; provides the debounced level and a one-cycle rising-edge pulse.
module btn_debounce
   import ped_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 160000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the accepted level.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Request-driven pedestrian crossing controller: phase FSM, one-second
// prescaler, saturating seconds counter, request latch and registered lamps.
module ped_crossing_ctrl
   import ped_pkg::*;
#(
   parameter int unsigned TIMER_SCALE = 16000000,
   parameter int unsigned DEBOUNCE    = 160000,
   parameter int unsigned MIN_GREEN_S = 10,
   parameter int unsigned GREEN_S     = 30,
   parameter bit          AUTO_CYCLE  = 1'b0,
   parameter int unsigned YELLOW_S    = 5,
   parameter int unsigned ALLRED_S    = 2,
   parameter int unsigned PED_GREEN_S = 10,
   parameter int unsigned PED_CLEAR_S = 5
) (
   input  logic pin3_clk_16mhz,
   input  logic pin2_rst,
   input  logic pin9_ped_button,
   output logic pin4_green,
   output logic pin5_yellow,
   output logic pin6_red,
   output logic pin7_ped_green,
   output logic pin8_ped_red,
   output logic pin10_wait
);

   if (TIMER_SCALE < 2 || (TIMER_SCALE % 2) != 0) begin : g_bad_scale
      $error("TIMER_SCALE must be even and >= 2");
   end
   if (DEBOUNCE < 1) begin : g_bad_debounce
      $error("DEBOUNCE must be >= 1");
   end
   if (MIN_GREEN_S < 1 || MIN_GREEN_S > 255 || GREEN_S < 1 || GREEN_S > 255 ||
       YELLOW_S < 1 || YELLOW_S > 255 || ALLRED_S < 1 || ALLRED_S > 255 ||
       PED_GREEN_S < 1 || PED_GREEN_S > 255 || PED_CLEAR_S < 1 || PED_CLEAR_S > 255 ||
       GREEN_S < MIN_GREEN_S) begin : g_bad_secs
      $error("phase durations must be 1..255 and GREEN_S >= MIN_GREEN_S");
   end

   localparam int unsigned PW = $clog2(TIMER_SCALE);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TIMER_SCALE - 1);
   localparam logic [PW-1:0]  PRESC_HALF = PW'(TIMER_SCALE / 2);
   localparam logic [SEC_W:0] MIN_GREEN_E = (SEC_W + 1)'(MIN_GREEN_S);
   localparam logic [SEC_W:0] GREEN_E     = (SEC_W + 1)'(GREEN_S);

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             req_q, req_d;
   lamps_t           lamps_q, lamps_d;
   logic             btn_level, btn_rise;
   logic             tick;
   logic [SEC_W:0]   elapsed;

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
      .clk_i   (pin3_clk_16mhz),
      .rst_i   (pin2_rst),
      .btn_i   (pin9_ped_button),
      .level_o (btn_level),
      .rise_o  (btn_rise)
   );

   assign tick    = (presc_q == PRESC_LAST);
   // Seconds completed once the current tick is counted.
   assign elapsed = {1'b0, sec_q} + 1'b1;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ALLRED0:    if (tick && sec_q == last_sec(ALLRED_S))    state_d = ROADGREEN;
         ROADGREEN:  if (tick && ((req_q && elapsed >= MIN_GREEN_E) ||
                                  (AUTO_CYCLE && elapsed >= GREEN_E)))
                                                                  state_d = ROADYELLOW;
         ROADYELLOW: if (tick && sec_q == last_sec(YELLOW_S))    state_d = ALLRED1;
         ALLRED1:    if (tick && sec_q == last_sec(ALLRED_S))    state_d = PEDGREEN;
         PEDGREEN:   if (tick && sec_q == last_sec(PED_GREEN_S)) state_d = PEDCLEAR;
         PEDCLEAR:   if (tick && sec_q == last_sec(PED_CLEAR_S)) state_d = ALLRED2;
         ALLRED2:    if (tick && sec_q == last_sec(ALLRED_S))    state_d = ROADGREEN;
         default:                                                 state_d = ALLRED0;
      endcase

      if (state_d != state_q) begin
         presc_d = '0;
         sec_d   = '0;
      end else if (tick) begin
         presc_d = '0;
         sec_d   = (sec_q == '1) ? sec_q : sec_q + 1'b1;
      end else begin
         presc_d = presc_q + 1'b1;
         sec_d   = sec_q;
      end

      // Entry into PEDGREEN clears the request even if an edge arrives together.
      req_d = req_q;
      if (state_d == PEDGREEN && state_q != PEDGREEN) begin
         req_d = 1'b0;
      end else if (btn_rise && btn_level && state_q != PEDGREEN) begin
         req_d = 1'b1;
      end

      unique case (state_q)
         ROADGREEN:  lamps_d = LAMPS_ROADGREEN;
         ROADYELLOW: lamps_d = LAMPS_ROADYELLOW;
         PEDGREEN:   lamps_d = LAMPS_PEDGREEN;
         PEDCLEAR:   lamps_d = {1'b0, (presc_q < PRESC_HALF), 3'b100};
         default:    lamps_d = LAMPS_ALLRED;
      endcase
   end

   always_ff @(posedge pin3_clk_16mhz) begin
      if (pin2_rst) begin
         state_q <= ALLRED0;
         presc_q <= '0;
         sec_q   <= '0;
         req_q   <= 1'b0;
         lamps_q <= LAMPS_ALLRED;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         sec_q   <= sec_d;
         req_q   <= req_d;
         lamps_q <= lamps_d;
      end
   end

   assign {pin8_ped_red, pin7_ped_green, pin6_red, pin5_yellow, pin4_green} = lamps_q;
   assign pin10_wait = req_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with small timing parameters; a second
// instance runs with AUTO_CYCLE=1 and no button.
module tb_ped_crossing_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;
   logic btn_auto = 1'b0;

   logic g, y, r, pg, pr, w;
   logic ga, ya, ra, pga, pra, wa;
   logic [4:0] lamps, lamps_a;

   int unsigned total = 0;
   int unsigned passes = 0;
   int unsigned fails = 0;

   localparam logic [4:0] L_ALLRED = 5'b10100;
   localparam logic [4:0] L_GREEN  = 5'b10001;
   localparam logic [4:0] L_YELLOW = 5'b10010;
   localparam logic [4:0] L_PEDGRN = 5'b01100;
   localparam logic [4:0] L_PEDOFF = 5'b00100;

   always #5 clk = ~clk;

   assign lamps   = {pr, pg, r, y, g};
   assign lamps_a = {pra, pga, ra, ya, ga};

   ped_crossing_ctrl #(
      .TIMER_SCALE(4), .DEBOUNCE(3), .MIN_GREEN_S(2), .GREEN_S(6), .AUTO_CYCLE(1'b0),
      .YELLOW_S(2), .ALLRED_S(1), .PED_GREEN_S(3), .PED_CLEAR_S(2)
   ) dut (
      .pin3_clk_16mhz (clk),
      .pin2_rst       (rst),
      .pin9_ped_button(btn),
      .pin4_green     (g),
      .pin5_yellow    (y),
      .pin6_red       (r),
      .pin7_ped_green (pg),
      .pin8_ped_red   (pr),
      .pin10_wait     (w)
   );

   ped_crossing_ctrl #(
      .TIMER_SCALE(4), .DEBOUNCE(3), .MIN_GREEN_S(2), .GREEN_S(6), .AUTO_CYCLE(1'b1),
      .YELLOW_S(2), .ALLRED_S(1), .PED_GREEN_S(3), .PED_CLEAR_S(2)
   ) dut_auto (
      .pin3_clk_16mhz (clk),
      .pin2_rst       (rst),
      .pin9_ped_button(btn_auto),
      .pin4_green     (ga),
      .pin5_yellow    (ya),
      .pin6_red       (ra),
      .pin7_ped_green (pga),
      .pin8_ped_red   (pra),
      .pin10_wait     (wa)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held for three edges.
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("rst_lamps", lamps, L_ALLRED);
         check("rst_wait", w, 1'b0);
      end
      rst = 1'b0;

      step(4);
      check("allred0_last", lamps, L_ALLRED);
      step(1);
      check("green_after_allred0", lamps, L_GREEN);
      check("auto_green", lamps_a, L_GREEN);
      step(23);
      check("auto_green_23", lamps_a, L_GREEN);
      step(1);
      check("auto_yellow_24", lamps_a, L_YELLOW);

      step(1971);
      check("hold_green", lamps, L_GREEN);
      check("hold_sec_sat", dut.sec_q, 8'd255);
      check("hold_wait", w, 1'b0);

      rst = 1'b1;
      step(3);
      rst = 1'b0;
      check("rst2_lamps", lamps, L_ALLRED);
      step(4);
      check("green_entry_lag", lamps, L_ALLRED);

      // Press at 1 s into green, held 10 cycles.
      step(4);
      btn = 1'b1;
      step(5);
      check("req_lat_5", w, 1'b0);
      step(1);
      check("req_lat_6", w, 1'b1);
      step(2);
      check("green_g12", lamps, L_GREEN);
      step(1);
      check("yellow_g13", lamps, L_YELLOW);
      step(1);
      btn = 1'b0;
      step(6);
      check("yellow_last", lamps, L_YELLOW);
      step(1);
      check("allred1_first", lamps, L_ALLRED);
      step(3);
      check("allred1_last", lamps, L_ALLRED);
      check("wait_clr_pedgreen", w, 1'b0);
      step(1);
      check("pedgreen_first", lamps, L_PEDGRN);
      step(11);
      check("pedgreen_last", lamps, L_PEDGRN);
      for (int i = 0; i < 8; i++) begin
         step(1);
         check("pedclear_flash", lamps, ((i % 4) < 2) ? L_PEDGRN : L_PEDOFF);
      end
      step(1);
      check("allred2_first", lamps, L_ALLRED);
      step(3);
      check("allred2_last", lamps, L_ALLRED);
      step(1);
      check("green_return", lamps, L_GREEN);

      // Bounce pulses of 1 and 2 cycles.
      btn = 1'b1; step(1);
      btn = 1'b0; step(3);
      btn = 1'b1; step(2);
      btn = 1'b0; step(6);
      check("bounce_no_req", w, 1'b0);

      // Held 5-cycle press.
      btn = 1'b1; step(5);
      btn = 1'b0;
      check("press5_lat5", w, 1'b0);
      step(1);
      check("press5_req", w, 1'b1);
      step(1);
      check("press5_green", lamps, L_GREEN);
      step(1);
      check("press5_yellow", lamps, L_YELLOW);

      // Press during PEDGREEN is ignored.
      step(12);
      check("pg2_lamps", lamps, L_PEDGRN);
      check("pg2_single_req", w, 1'b0);
      btn = 1'b1; step(5);
      btn = 1'b0; step(5);
      check("pg_press_ignored", w, 1'b0);

      // Press during PEDCLEAR is latched and served next green.
      step(2);
      btn = 1'b1; step(5);
      btn = 1'b0;
      check("pc_press_lat5", w, 1'b0);
      step(1);
      check("pc_press_req", w, 1'b1);
      step(13);
      check("next_green_2s", lamps, L_GREEN);
      check("next_green_wait", w, 1'b1);
      step(1);
      check("next_yellow_2s", lamps, L_YELLOW);

      // Reset mid-PEDCLEAR with a request pending.
      step(24);
      check("pc3_flash_on", lamps, L_PEDGRN);
      btn = 1'b1; step(5);
      btn = 1'b0; step(1);
      check("pc3_req", w, 1'b1);
      rst = 1'b1;
      step(1);
      check("midrst_lamps", lamps, L_ALLRED);
      check("midrst_wait", w, 1'b0);
      rst = 1'b0;
      step(4);
      check("midrst_allred0", lamps, L_ALLRED);
      step(1);
      check("midrst_green", lamps, L_GREEN);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
